// File: rtl/pc_sequencer_if.sv
// Bus between the control block and the PC sequencer: strobe/offset/resume in,
// PC, run state and instruction count out.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned CNT_W = 32;

  logic             pc_count;
  logic [WIDTH-1:0] addr_imm;
  logic             resume;
  logic [WIDTH-1:0] bp_addr;
  logic             bp_valid;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_prev;
  logic             run_en;
  logic             halted;
  logic             at_break;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output pc_count, addr_imm, resume, bp_addr, bp_valid,
    input  pc, pc_prev, run_en, halted, at_break, instr_count
  );

  modport slave (
    input  pc_count, addr_imm, resume, bp_addr, bp_valid,
    output pc, pc_prev, run_en, halted, at_break, instr_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage: advances PC on rising edges of the control block's
// PCcount strobe, detects halt, supports resume. Optional breakpoint: PC_BREAKPOINT_EN.
module pc_sequencer #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          reset,
  pc_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_BREAK = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_prev_q, pc_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             skip_q, skip_d;
  logic             pc_count_q;
  logic             run_en_q, halted_q;

  logic             upd;
  logic             halt_off;
  logic             take;
  logic [WIDTH-1:0] pc_sum;

  // Next-state and update selection
  always_comb begin
    upd       = bus.pc_count & ~pc_count_q;
    halt_off  = (bus.addr_imm == '1);
    pc_sum    = pc_q + WIDTH'(1) + bus.addr_imm;
    state_d   = state_q;
    pc_d      = pc_q;
    pc_prev_d = pc_prev_q;
    cnt_d     = cnt_q;
    skip_d    = skip_q;
    take      = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (upd) begin
          take = 1'b1;
          pc_d = pc_sum;
          if (halt_off) begin
            state_d = S_HALT;
          end
`ifdef PC_BREAKPOINT_EN
          else if (bus.bp_valid && (pc_sum == bus.bp_addr)) begin
            state_d = S_BREAK;
          end
`endif
        end
      end
      S_HALT: begin
        // A resume in the same cycle as the strobe counts as resume-then-update
        if (upd && (skip_q || bus.resume)) begin
          take    = 1'b1;
          pc_d    = pc_q + WIDTH'(1);
          skip_d  = 1'b0;
          state_d = S_RUN;
        end else if (bus.resume) begin
          skip_d = 1'b1;
        end
      end
      S_BREAK: begin
        if (bus.resume) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase

    if (take) begin
      pc_prev_d = pc_q;
      cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      pc_prev_q  <= RESET_PC;
      cnt_q      <= '0;
      skip_q     <= 1'b0;
      pc_count_q <= 1'b1;
      run_en_q   <= 1'b1;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_prev_q  <= pc_prev_d;
      cnt_q      <= cnt_d;
      skip_q     <= skip_d;
      pc_count_q <= bus.pc_count;
      run_en_q   <= (state_d == S_RUN);
      halted_q   <= (state_d == S_HALT);
    end
  end

`ifdef PC_BREAKPOINT_EN
  logic at_break_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      at_break_q <= 1'b0;
    end else begin
      at_break_q <= (state_d == S_BREAK);
    end
  end

  assign bus.at_break = at_break_q;
`else
  logic unused_bp;

  assign unused_bp    = ^{bus.bp_addr, bus.bp_valid};
  assign bus.at_break = 1'b0;
`endif

  assign bus.pc          = pc_q;
  assign bus.pc_prev     = pc_prev_q;
  assign bus.instr_count = cnt_q;
  assign bus.run_en      = run_en_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, stepping, wrap, halt/resume, breakpoint, async reset.
module tb_pc_sequencer;

`ifdef PC_BREAKPOINT_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One PCcount low->high cycle carrying the given offset; optional coincident resume
  task automatic strobe(input logic [31:0] off, input logic res);
    bus.pc_count = 1'b0;
    bus.addr_imm = off;
    tick();
    bus.pc_count = 1'b1;
    bus.resume   = res;
    tick();
    bus.resume   = 1'b0;
  endtask

  task automatic pulse_resume();
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    reset        = 1'b0;
    bus.pc_count = 1'b1;
    bus.addr_imm = 32'h0;
    bus.resume   = 1'b0;
    bus.bp_addr  = 32'h0;
    bus.bp_valid = 1'b0;
    tick();
    tick();
    check("rst_pc",       64'(bus.pc), 64'h0);
    check("rst_pc_prev",  64'(bus.pc_prev), 64'h0);
    check("rst_count",    64'(bus.instr_count), 64'h0);
    check("rst_run_en",   64'(bus.run_en), 64'h1);
    check("rst_halted",   64'(bus.halted), 64'h0);
    check("rst_at_break", 64'(bus.at_break), 64'h0);

    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("hold_high_pc",    64'(bus.pc), 64'h0);
    check("hold_high_count", 64'(bus.instr_count), 64'h0);

    for (int i = 0; i < 3; i++) strobe(32'h0, 1'b0);
    check("step3_pc",      64'(bus.pc), 64'h3);
    check("step3_pc_prev", 64'(bus.pc_prev), 64'h2);
    check("step3_count",   64'(bus.instr_count), 64'h3);

    strobe(32'hFFFF_FFFC, 1'b0);
    check("neg_off_pc",      64'(bus.pc), 64'h0);
    check("neg_off_pc_prev", 64'(bus.pc_prev), 64'h3);
    check("neg_off_count",   64'(bus.instr_count), 64'h4);

    strobe(32'h6, 1'b0);
    check("to7_pc", 64'(bus.pc), 64'h7);

    strobe(32'hFFFF_FFFF, 1'b0);
    check("halt_pc",     64'(bus.pc), 64'h7);
    check("halt_flag",   64'(bus.halted), 64'h1);
    check("halt_run_en", 64'(bus.run_en), 64'h0);

    strobe(32'hFFFF_FFFF, 1'b0);
    strobe(32'hFFFF_FFFF, 1'b0);
    check("halt_ign_pc",   64'(bus.pc), 64'h7);
    check("halt_ign_flag", 64'(bus.halted), 64'h1);

    pulse_resume();
    check("resume_still_halted", 64'(bus.halted), 64'h1);
    check("resume_run_en_low",   64'(bus.run_en), 64'h0);
    strobe(32'hFFFF_FFFF, 1'b0);
    check("skip_pc",     64'(bus.pc), 64'h8);
    check("skip_halted", 64'(bus.halted), 64'h0);
    check("skip_run_en", 64'(bus.run_en), 64'h1);

    strobe(32'hFFFF_FFFF, 1'b0);
    check("halt2_flag", 64'(bus.halted), 64'h1);
    strobe(32'hFFFF_FFFF, 1'b1);
    check("coinc_pc",      64'(bus.pc), 64'h9);
    check("coinc_pc_prev", 64'(bus.pc_prev), 64'h8);
    check("coinc_halted",  64'(bus.halted), 64'h0);
    check("coinc_run_en",  64'(bus.run_en), 64'h1);

    strobe(32'hFFFF_FFF5, 1'b0);
    check("to_max_pc", 64'(bus.pc), 64'hFFFF_FFFF);
    strobe(32'h0, 1'b0);
    check("wrap_pc",      64'(bus.pc), 64'h0);
    check("wrap_pc_prev", 64'(bus.pc_prev), 64'hFFFF_FFFF);

    // Resume in RUN must not pre-arm the halt skip
    pulse_resume();
    strobe(32'hFFFF_FFFF, 1'b0);
    check("run_resume_pc",     64'(bus.pc), 64'h0);
    check("run_resume_halted", 64'(bus.halted), 64'h1);

    pulse_resume();
    strobe(32'hB, 1'b0);
    check("to12_pc", 64'(bus.pc), 64'h1);
    strobe(32'hA, 1'b0);
    check("to12b_pc", 64'(bus.pc), 64'hC);
    strobe(32'hFFFF_FFFF, 1'b0);
    check("halt12_flag", 64'(bus.halted), 64'h1);

    #2;
    reset = 1'b0;
    #1;
    check("async_rst_pc",      64'(bus.pc), 64'h0);
    check("async_rst_pc_prev", 64'(bus.pc_prev), 64'h0);
    check("async_rst_halted",  64'(bus.halted), 64'h0);
    check("async_rst_count",   64'(bus.instr_count), 64'h0);
    check("async_rst_run_en",  64'(bus.run_en), 64'h1);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("post_rst_pc", 64'(bus.pc), 64'h0);

    bus.bp_addr  = 32'h5;
    bus.bp_valid = 1'b1;
    strobe(32'h3, 1'b0);
    check("bp_pre_pc", 64'(bus.pc), 64'h4);
    strobe(32'h0, 1'b0);
    check("bp_hit_pc",       64'(bus.pc), 64'h5);
    check("bp_hit_at_break", 64'(bus.at_break), BP ? 64'h1 : 64'h0);
    check("bp_hit_run_en",   64'(bus.run_en), BP ? 64'h0 : 64'h1);
    strobe(32'h0, 1'b0);
    check("bp_ign_pc", 64'(bus.pc), BP ? 64'h5 : 64'h6);
    pulse_resume();
    check("bp_resume_run_en",   64'(bus.run_en), 64'h1);
    check("bp_resume_at_break", 64'(bus.at_break), 64'h0);
    strobe(32'h0, 1'b0);
    check("bp_after_pc",    64'(bus.pc), BP ? 64'h6 : 64'h7);
    check("bp_after_count", 64'(bus.instr_count), BP ? 64'h3 : 64'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
